pipe_mem: RTL and testbench

PIPE_MEM -- requirements
Module: pipe_mem

---
 rtl/pipe_mem_pkg.sv | 37 +++
 rtl/pipe_mem_if.sv | 21 ++
 rtl/pipe_mem_lsu_align.sv | 38 +++
 rtl/pipe_mem.sv | 174 +++++++++++++++++
 tb/tb_pipe_mem.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_mem_pkg.sv
// Shared pipe definitions: size codes, FSM states, timeout default.
// Also holds the latched memory-op bundle and the alignment check.
package pipe_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int TIMEOUT_DEF = 15;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic        wreg;
    logic        wmem;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rn;
  } mem_op_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/pipe_mem_if.sv
// Data-memory bus between the MEM stage (master) and memory (slave).
// Request held until ack; rdata valid in the ack cycle.
interface pipe_mem_if;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/pipe_mem_lsu_align.sv
// lsu_align: byte enables, store replication, load extract/extend.
// Ports: size, a (addr[1:0]), uns, st_in/rd_in -> be, st_out, ld_out.
module lsu_align
  import pipe_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  a,
  input  logic        uns,
  input  logic [31:0] st_in,
  input  logic [31:0] rd_in,
  output logic [3:0]  be,
  output logic [31:0] st_out,
  output logic [31:0] ld_out
);

  logic [31:0] sh;
  assign sh = rd_in >> {a, 3'b000};

  always_comb begin
    be     = 4'b1111;
    st_out = st_in;
    ld_out = rd_in;
    unique case (1'b1)
      size == SZ_B: begin
        be     = 4'b0001 << a;
        st_out = {4{st_in[7:0]}};
        ld_out = {{24{~uns & sh[7]}}, sh[7:0]};
      end
      size == SZ_H: begin
        be     = 4'b0011 << a;
        st_out = {2{st_in[15:0]}};
        ld_out = {{16{~uns & sh[15]}}, sh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_mem.sv
// pipe_mem: MEM stage, IDLE/REQ FSM driving dm bus, wb registers.
// Ports: clk, clrn, ex_*, mem_stall, dm (master), wb_*, mem_err. Option: PIPE_MEM_TIMEOUT_EN.
module pipe_mem
  import pipe_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ex_valid,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic        ex_wmem,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_alu,
  input  logic [4:0]  ex_rn,
  output logic        mem_stall,
  pipe_mem_if.master  dm,
  output logic        wb_valid,
  output logic        wb_wreg,
  output logic [4:0]  wb_rn,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  state_t  state, state_n;
  mem_op_t op;
  logic    in_req;
  logic    is_mem, mis;
  logic    take, do_alu, do_mis;
  logic    done, abort, to_hit;
  logic [3:0]  be;
  logic [31:0] st, ld;

  assign in_req = (state == S_REQ);
  assign is_mem = ex_m2reg | ex_wmem;
  assign mis    = misaligned(ex_size, ex_addr[1:0]);

  lsu_align u_align (
    .size   (op.size),
    .a      (op.addr[1:0]),
    .uns    (op.uns),
    .st_in  (op.wdata),
    .rd_in  (dm.dm_rdata),
    .be     (be),
    .st_out (st),
    .ld_out (ld)
  );

`ifdef PIPE_MEM_TIMEOUT_EN
  logic [7:0] to_cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)       to_cnt <= '0;
    else if (take)   to_cnt <= '0;
    else if (in_req) to_cnt <= to_cnt + 8'd1;
  end

  assign to_hit = in_req &&
    (to_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  logic unused_to;
  assign unused_to = (TIMEOUT_CYCLES != 0);
  assign to_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mem_stall = 1'b0;
    take      = 1'b0;
    do_alu    = 1'b0;
    do_mis    = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            do_alu = 1'b1;
          end else if (mis) begin
            do_mis = 1'b1;
          end else begin
            take      = 1'b1;
            mem_stall = 1'b1;
            state_n   = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dm.dm_ack) begin
          done    = 1'b1;
          state_n = S_IDLE;
        end else if (to_hit) begin
          abort   = 1'b1;
          state_n = S_IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Stall must read 0 while reset is held, even with EX valid.
    if (!clrn) mem_stall = 1'b0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) op <= '0;
    else if (take) begin
      op.wreg  <= ex_wreg;
      op.wmem  <= ex_wmem;
      op.size  <= ex_size;
      op.uns   <= ex_unsigned;
      op.addr  <= ex_addr;
      op.wdata <= ex_wdata;
      op.rn    <= ex_rn;
    end
  end

  assign dm.dm_req   = in_req;
  assign dm.dm_we    = in_req & op.wmem;
  assign dm.dm_be    = in_req ? be : 4'b0000;
  assign dm.dm_addr  = in_req ? {op.addr[31:2], 2'b00} : '0;
  assign dm.dm_wdata = in_req ? st : '0;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wb_valid <= 1'b0;
      wb_wreg  <= 1'b0;
      wb_rn    <= '0;
      wb_data  <= '0;
      mem_err  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_wreg  <= 1'b0;
      mem_err  <= 1'b0;
      unique case (1'b1)
        do_alu: begin
          wb_valid <= 1'b1;
          wb_wreg  <= ex_wreg;
          wb_rn    <= ex_rn;
          wb_data  <= ex_alu;
        end
        do_mis: begin
          wb_valid <= 1'b1;
          mem_err  <= 1'b1;
          wb_rn    <= ex_rn;
          wb_data  <= '0;
        end
        done: begin
          wb_valid <= 1'b1;
          wb_wreg  <= op.wreg & ~op.wmem;
          wb_rn    <= op.rn;
          wb_data  <= op.wmem ? '0 : ld;
        end
        abort: begin
          wb_valid <= 1'b1;
          mem_err  <= 1'b1;
          wb_rn    <= op.rn;
          wb_data  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem.sv
// Directed testbench for pipe_mem.
// One task per scenario; inline comparisons; summary line at end.
module tb_pipe_mem;
  import pipe_mem_pkg::*;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        ex_valid, ex_wreg, ex_m2reg, ex_wmem;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [31:0] ex_addr, ex_wdata, ex_alu;
  logic [4:0]  ex_rn;
  logic        mem_stall;
  logic        wb_valid, wb_wreg, mem_err;
  logic [4:0]  wb_rn;
  logic [31:0] wb_data;

  int n_run = 0;
  int n_fail = 0;

  pipe_mem_if dm_bus ();

  pipe_mem dut (
    .clk         (clk),
    .clrn        (clrn),
    .ex_valid    (ex_valid),
    .ex_wreg     (ex_wreg),
    .ex_m2reg    (ex_m2reg),
    .ex_wmem     (ex_wmem),
    .ex_size     (ex_size),
    .ex_unsigned (ex_unsigned),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .ex_alu      (ex_alu),
    .ex_rn       (ex_rn),
    .mem_stall   (mem_stall),
    .dm          (dm_bus.master),
    .wb_valid    (wb_valid),
    .wb_wreg     (wb_wreg),
    .wb_rn       (wb_rn),
    .wb_data     (wb_data),
    .mem_err     (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_ex(
    input logic v, input logic wr, input logic ld,
    input logic stv, input logic [1:0] sz,
    input logic un, input logic [31:0] a,
    input logic [31:0] wd, input logic [31:0] alu,
    input logic [4:0] rn
  );
    ex_valid = v; ex_wreg = wr; ex_m2reg = ld;
    ex_wmem = stv; ex_size = sz; ex_unsigned = un;
    ex_addr = a; ex_wdata = wd; ex_alu = alu;
    ex_rn = rn;
  endtask

  task automatic clear_ex();
    set_ex(0, 0, 0, 0, SZ_W, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    set_ex(1, 1, 1, 0, SZ_W, 0, 32'h100, 0, 0, 1);
    dm_bus.dm_ack = 1'b0;
    dm_bus.dm_rdata = '0;
    #12;
    n_run++;
    if (mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stall got=%b exp=0", mem_stall);
    end
    n_run++;
    if ({dm_bus.dm_req, dm_bus.dm_be} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_dm got=%b%b exp=0",
        dm_bus.dm_req, dm_bus.dm_be);
    end
    n_run++;
    if ({wb_valid, wb_wreg, mem_err, wb_data} !== 35'b0)
    begin
      n_fail++;
      $display("FAIL rst_wb got=%b%b%b %h exp=0",
        wb_valid, wb_wreg, mem_err, wb_data);
    end
    clear_ex();
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_alu();
    @(posedge clk); #1;
    set_ex(1, 1, 0, 0, SZ_W, 0, 0, 0, 32'h1234, 5);
    #1;
    n_run++;
    if (mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_stall got=%b exp=0", mem_stall);
    end
    @(posedge clk); #1;
    clear_ex();
    n_run++;
    if ({wb_valid, wb_wreg, wb_rn, wb_data} !==
        {1'b1, 1'b1, 5'd5, 32'h1234}) begin
      n_fail++;
      $display("FAIL alu_wb got=%b%b %0d %h exp=1 1 5 1234",
        wb_valid, wb_wreg, wb_rn, wb_data);
    end
    @(posedge clk); #1;
    n_run++;
    if (wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_pulse got=%b exp=0", wb_valid);
    end
  endtask

  task automatic test_load_byte();
    int stalls;
    stalls = 0;
    @(posedge clk); #1;
    set_ex(1, 1, 1, 0, SZ_B, 0, 32'h103, 0, 0, 7);
    #1;
    if (mem_stall === 1'b1) stalls++;
    n_run++;
    if (dm_bus.dm_req !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_req_idle got=%b exp=0", dm_bus.dm_req);
    end
    @(posedge clk); #1;
    n_run++;
    if ({dm_bus.dm_req, dm_bus.dm_we, dm_bus.dm_be,
         dm_bus.dm_addr} !== {2'b10, 4'b1000, 32'h100}) begin
      n_fail++;
      $display("FAIL lb_bus got=%b%b %b %h exp=1 0 1000 100",
        dm_bus.dm_req, dm_bus.dm_we, dm_bus.dm_be,
        dm_bus.dm_addr);
    end
    if (mem_stall === 1'b1) stalls++;
    @(posedge clk); #1;
    if (mem_stall === 1'b1) stalls++;
    @(posedge clk); #1;
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 32'h80FF_FFFF;
    #1;
    if (mem_stall === 1'b1) stalls++;
    @(posedge clk); #1;
    dm_bus.dm_ack = 1'b0;
    clear_ex();
    n_run++;
    if (stalls != 3) begin
      n_fail++;
      $display("FAIL lb_stall_cycles got=%0d exp=3", stalls);
    end
    n_run++;
    if ({wb_valid, wb_wreg, wb_rn, wb_data} !==
        {1'b1, 1'b1, 5'd7, 32'hFFFF_FF80}) begin
      n_fail++;
      $display("FAIL lb_wb got=%b%b %0d %h exp=1 1 7 ffffff80",
        wb_valid, wb_wreg, wb_rn, wb_data);
    end
    n_run++;
    if (dm_bus.dm_req !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_req_done got=%b exp=0", dm_bus.dm_req);
    end
  endtask

  task automatic test_load_half();
    @(posedge clk); #1;
    set_ex(1, 1, 1, 0, SZ_H, 1, 32'h202, 0, 0, 8);
    @(posedge clk); #1;
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 32'h8765_4321;
    n_run++;
    if (dm_bus.dm_be !== 4'b1100) begin
      n_fail++;
      $display("FAIL lhu_be got=%b exp=1100", dm_bus.dm_be);
    end
    @(posedge clk); #1;
    dm_bus.dm_ack = 1'b0;
    n_run++;
    if (wb_data !== 32'h0000_8765) begin
      n_fail++;
      $display("FAIL lhu_data got=%h exp=00008765", wb_data);
    end
    set_ex(1, 1, 1, 0, SZ_H, 0, 32'h200, 0, 0, 8);
    @(posedge clk); #1;
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 32'h1234_F00D;
    @(posedge clk); #1;
    dm_bus.dm_ack = 1'b0;
    clear_ex();
    n_run++;
    if (wb_data !== 32'hFFFF_F00D) begin
      n_fail++;
      $display("FAIL lh_data got=%h exp=fffff00d", wb_data);
    end
  endtask

  task automatic test_store_half();
    @(posedge clk); #1;
    set_ex(1, 1, 0, 1, SZ_H, 0, 32'h102, 32'hABCD_1234, 0, 3);
    @(posedge clk); #1;
    n_run++;
    if ({dm_bus.dm_we, dm_bus.dm_be, dm_bus.dm_wdata,
         dm_bus.dm_addr} !==
        {1'b1, 4'b1100, 32'h1234_1234, 32'h100}) begin
      n_fail++;
      $display("FAIL sh_bus got=%b %b %h %h exp=1 1100 12341234 100",
        dm_bus.dm_we, dm_bus.dm_be, dm_bus.dm_wdata,
        dm_bus.dm_addr);
    end
    dm_bus.dm_ack = 1'b1;
    #1;
    n_run++;
    if (mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL sh_ack_stall got=%b exp=0", mem_stall);
    end
    @(posedge clk); #1;
    dm_bus.dm_ack = 1'b0;
    clear_ex();
    n_run++;
    if ({wb_valid, wb_wreg, mem_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL sh_wb got=%b%b%b exp=100",
        wb_valid, wb_wreg, mem_err);
    end
  endtask

  task automatic test_byte_store();
    @(posedge clk); #1;
    set_ex(1, 0, 0, 1, SZ_B, 0, 32'h305, 32'h0000_00A5, 0, 0);
    @(posedge clk); #1;
    n_run++;
    if ({dm_bus.dm_be, dm_bus.dm_wdata, dm_bus.dm_addr} !==
        {4'b0010, 32'hA5A5_A5A5, 32'h304}) begin
      n_fail++;
      $display("FAIL sb_bus got=%b %h %h exp=0010 a5a5a5a5 304",
        dm_bus.dm_be, dm_bus.dm_wdata, dm_bus.dm_addr);
    end
    dm_bus.dm_ack = 1'b1;
    @(posedge clk); #1;
    dm_bus.dm_ack = 1'b0;
    clear_ex();
  endtask

  task automatic test_misaligned();
    @(posedge clk); #1;
    set_ex(1, 1, 1, 0, SZ_W, 0, 32'h101, 0, 0, 6);
    #1;
    n_run++;
    if ({dm_bus.dm_req, mem_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL mis_w_req got=%b%b exp=00",
        dm_bus.dm_req, mem_stall);
    end
    @(posedge clk); #1;
    set_ex(1, 1, 0, 1, SZ_H, 0, 32'h103, 0, 0, 6);
    n_run++;
    if ({mem_err, wb_valid, wb_wreg, dm_bus.dm_req} !==
        4'b1100) begin
      n_fail++;
      $display("FAIL mis_w_wb got=%b%b%b%b exp=1100",
        mem_err, wb_valid, wb_wreg, dm_bus.dm_req);
    end
    @(posedge clk); #1;
    clear_ex();
    n_run++;
    if ({mem_err, wb_valid, wb_wreg, dm_bus.dm_req} !==
        4'b1100) begin
      n_fail++;
      $display("FAIL mis_h_wb got=%b%b%b%b exp=1100",
        mem_err, wb_valid, wb_wreg, dm_bus.dm_req);
    end
    @(posedge clk); #1;
    n_run++;
    if ({mem_err, wb_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL mis_pulse got=%b%b exp=00",
        mem_err, wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    dm_bus.dm_ack = 1'b1;
    @(posedge clk); #1;
    dm_bus.dm_ack = 1'b0;
    n_run++;
    if ({wb_valid, dm_bus.dm_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_ack got=%b%b exp=00",
        wb_valid, dm_bus.dm_req);
    end
    set_ex(1, 1, 1, 0, SZ_W, 0, 32'h200, 0, 0, 4);
    @(posedge clk); #1;
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 32'hDEAD_BEEF;
    set_ex(1, 1, 0, 0, SZ_W, 0, 0, 0, 32'h55, 9);
    @(posedge clk); #1;
    dm_bus.dm_ack = 1'b0;
    n_run++;
    if ({wb_valid, wb_rn, wb_data, dm_bus.dm_req} !==
        {1'b1, 5'd4, 32'hDEAD_BEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_load got=%b %0d %h %b exp=1 4 deadbeef 0",
        wb_valid, wb_rn, wb_data, dm_bus.dm_req);
    end
    @(posedge clk); #1;
    clear_ex();
    n_run++;
    if ({wb_valid, wb_rn, wb_data} !==
        {1'b1, 5'd9, 32'h55}) begin
      n_fail++;
      $display("FAIL b2b_alu got=%b %0d %h exp=1 9 55",
        wb_valid, wb_rn, wb_data);
    end
  endtask

  task automatic test_timeout();
    int hi;
    hi = 0;
    @(posedge clk); #1;
    set_ex(1, 1, 1, 0, SZ_W, 0, 32'h300, 0, 0, 2);
    @(posedge clk); #1;
    clear_ex();
`ifdef PIPE_MEM_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      if (dm_bus.dm_req !== 1'b1) break;
      hi++;
      @(posedge clk); #1;
    end
    n_run++;
    if (hi != 15) begin
      n_fail++;
      $display("FAIL to_req_cycles got=%0d exp=15", hi);
    end
    n_run++;
    if ({mem_err, wb_valid, wb_wreg} !== 3'b110) begin
      n_fail++;
      $display("FAIL to_err got=%b%b%b exp=110",
        mem_err, wb_valid, wb_wreg);
    end
`else
    for (int i = 0; i < 100; i++) begin
      if (dm_bus.dm_req === 1'b1) hi++;
      @(posedge clk); #1;
    end
    n_run++;
    if (hi != 100) begin
      n_fail++;
      $display("FAIL noto_req_cycles got=%0d exp=100", hi);
    end
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 32'h0000_0042;
    @(posedge clk); #1;
    dm_bus.dm_ack = 1'b0;
    n_run++;
    if ({wb_valid, mem_err, wb_data} !==
        {2'b10, 32'h42}) begin
      n_fail++;
      $display("FAIL noto_done got=%b%b %h exp=1 0 42",
        wb_valid, mem_err, wb_data);
    end
`endif
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    set_ex(1, 1, 1, 0, SZ_W, 0, 32'h104, 0, 0, 1);
    @(posedge clk); #1;
    n_run++;
    if (dm_bus.dm_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_pre_req got=%b exp=1", dm_bus.dm_req);
    end
    #2;
    clrn = 1'b0;
    #1;
    n_run++;
    if ({dm_bus.dm_req, mem_stall, wb_valid,
         dm_bus.dm_be} !== 7'b0) begin
      n_fail++;
      $display("FAIL rm_outs got=%b%b%b %b exp=0",
        dm_bus.dm_req, mem_stall, wb_valid, dm_bus.dm_be);
    end
    set_ex(1, 1, 0, 0, SZ_W, 0, 0, 0, 32'h77, 2);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk); #1;
    clear_ex();
    n_run++;
    if ({wb_valid, wb_wreg, wb_rn, wb_data} !==
        {1'b1, 1'b1, 5'd2, 32'h77}) begin
      n_fail++;
      $display("FAIL rm_post got=%b%b %0d %h exp=1 1 2 77",
        wb_valid, wb_wreg, wb_rn, wb_data);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_load_half();
    test_store_half();
    test_byte_store();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
